// File: rtl/cart_bus_bridge.sv
// CPU/PPU to cartridge mapper bridge.
// Two independent PRG/CHR channels with strobe, timeout and open-bus.
module cart_bus_chan #(
  parameter int          AW             = 16,
  parameter int          TIMEOUT_CYCLES = 4,
  parameter logic [7:0]  OPEN_BUS_RESET = 8'h00
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic          i_rw,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_wdata,
  output logic          o_busy,
  output logic          o_ack,
  output logic [7:0]    o_rdata,
  output logic          o_rd,
  output logic          o_wr,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_wdata,
  input  logic          i_en,
  input  logic [7:0]    i_din
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_ACK
  } state_t;

  localparam logic [3:0] TMO_LAST = 4'(TIMEOUT_CYCLES - 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_cnt;
  logic [3:0]    w_cnt_nxt;
  logic          w_load;
  logic          w_hit;
  logic          w_tmo;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_wdata;
  logic [7:0]    r_rdata;
  logic [7:0]    r_ob;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_hit       = 1'b0;
    w_tmo       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_req) begin
          w_load      = 1'b1;
          w_state_nxt = i_rw ? S_READ : S_WRITE;
        end
      end
      S_READ: begin
        // a late data-enable still wins on the timeout edge
        if (i_en) begin
          w_hit       = 1'b1;
          w_state_nxt = S_ACK;
        end else if (r_cnt == TMO_LAST) begin
          w_tmo       = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt + 4'd1;
        end
      end
      S_WRITE: w_state_nxt = S_ACK;
      S_ACK: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_ob    <= OPEN_BUS_RESET;
    end else begin
      if (w_load) begin
        r_addr  <= i_addr;
        r_wdata <= i_wdata;
      end
      if (w_hit) begin
        r_rdata <= i_din;
        r_ob    <= i_din;
      end else if (w_tmo) begin
        r_rdata <= r_ob;
      end
    end
  end

  assign o_busy  = (r_state != S_IDLE);
  assign o_ack   = (r_state == S_ACK);
  assign o_rd    = (r_state == S_READ);
  assign o_wr    = (r_state == S_WRITE);
  assign o_addr  = r_addr;
  assign o_wdata = r_wdata;
  assign o_rdata = r_rdata;

endmodule

module cart_bus_bridge #(
  parameter int         TIMEOUT_CYCLES = 4,
  parameter logic [7:0] OPEN_BUS_RESET = 8'h00
) (
  input  logic        cart_clk_in,
  input  logic        cart_reset_in,
  input  logic        cpu_req_in,
  input  logic        cpu_rw_in,
  input  logic [15:0] cpu_address_in,
  input  logic [7:0]  cpu_data_in,
  output logic        cpu_busy_out,
  output logic        cpu_ack_out,
  output logic [7:0]  cpu_data_out,
  input  logic        ppu_req_in,
  input  logic        ppu_rw_in,
  input  logic [13:0] ppu_address_in,
  input  logic [7:0]  ppu_data_in,
  output logic        ppu_busy_out,
  output logic        ppu_ack_out,
  output logic [7:0]  ppu_data_out,
  output logic        prg_read_out,
  output logic        prg_write_out,
  output logic [15:0] prg_address_out,
  output logic [7:0]  prg_wdata_out,
  input  logic        prg_data_en_in,
  input  logic [7:0]  prg_data_in,
  output logic        chr_read_out,
  output logic        chr_write_out,
  output logic [13:0] chr_address_out,
  output logic [7:0]  chr_wdata_out,
  input  logic        chr_data_en_in,
  input  logic [7:0]  chr_data_in
);

  cart_bus_chan #(
    .AW             (16),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .OPEN_BUS_RESET (OPEN_BUS_RESET)
  ) u_prg (
    .i_clk   (cart_clk_in),
    .i_rst   (cart_reset_in),
    .i_req   (cpu_req_in),
    .i_rw    (cpu_rw_in),
    .i_addr  (cpu_address_in),
    .i_wdata (cpu_data_in),
    .o_busy  (cpu_busy_out),
    .o_ack   (cpu_ack_out),
    .o_rdata (cpu_data_out),
    .o_rd    (prg_read_out),
    .o_wr    (prg_write_out),
    .o_addr  (prg_address_out),
    .o_wdata (prg_wdata_out),
    .i_en    (prg_data_en_in),
    .i_din   (prg_data_in)
  );

  cart_bus_chan #(
    .AW             (14),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .OPEN_BUS_RESET (OPEN_BUS_RESET)
  ) u_chr (
    .i_clk   (cart_clk_in),
    .i_rst   (cart_reset_in),
    .i_req   (ppu_req_in),
    .i_rw    (ppu_rw_in),
    .i_addr  (ppu_address_in),
    .i_wdata (ppu_data_in),
    .o_busy  (ppu_busy_out),
    .o_ack   (ppu_ack_out),
    .o_rdata (ppu_data_out),
    .o_rd    (chr_read_out),
    .o_wr    (chr_write_out),
    .o_addr  (chr_address_out),
    .o_wdata (chr_wdata_out),
    .i_en    (chr_data_en_in),
    .i_din   (chr_data_in)
  );

endmodule
